// File: rtl/swipt_link_ctrl_pkg.sv
// swipt_pkg: shared state encoding and frame/modulator constants for the SWIPT link controller.
package swipt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_GUARD,
        ST_RX
    } swipt_link_state_t;

    localparam logic        SWIPT_START_BIT = 1'b1;
    localparam logic        SWIPT_STOP_BIT  = 1'b0;
    localparam logic [1:0]  SWIPT_PROG_IDLE = 2'b00;
    localparam logic [1:0]  SWIPT_PROG_TX   = 2'b11;
    localparam logic [11:0] SWIPT_DUTY_MAX  = 12'h1F4;

endpackage

// File: rtl/swipt_link_ctrl_if.sv
// swipt_link_ctrl_if: requester handshakes and modulator-facing strobes of the link controller.
interface swipt_link_ctrl_if;

    logic       swipt_alive_i;
    logic       tx_valid_i;
    logic [7:0] tx_byte_i;
    logic       tx_ready_o;
    logic       rx_req_i;
    logic       rx_grant_o;
    logic [1:0] program_o;
    logic       write_o;
    logic       read_o;
    logic       data_o;
    logic       busy_o;
    logic       tx_done_o;
    logic       abort_o;

    modport master (
        output swipt_alive_i, tx_valid_i, tx_byte_i, rx_req_i,
        input  tx_ready_o, rx_grant_o, program_o, write_o, read_o, data_o, busy_o, tx_done_o, abort_o
    );

    modport slave (
        input  swipt_alive_i, tx_valid_i, tx_byte_i, rx_req_i,
        output tx_ready_o, rx_grant_o, program_o, write_o, read_o, data_o, busy_o, tx_done_o, abort_o
    );

endinterface

// File: rtl/swipt_link_ctrl_arb.sv
// swipt_link_arb: two-requester round-robin arbiter; the requester not served last wins a tie.
module swipt_link_arb (
    input  logic clk,
    input  logic nrst,
    input  logic en_i,
    input  logic tx_req_i,
    input  logic rx_req_i,
    input  logic upd_i,
    input  logic upd_rx_i,
    output logic gnt_tx_o,
    output logic gnt_rx_o
);

    logic last_rx_q;

    assign gnt_tx_o = en_i && tx_req_i && (!rx_req_i || last_rx_q);
    assign gnt_rx_o = en_i && rx_req_i && (!tx_req_i || !last_rx_q);

    // Starts as "RX served last" so TX takes the first contention.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            last_rx_q <= 1'b1;
        else if (upd_i)
            last_rx_q <= upd_rx_i;
    end

endmodule

// File: rtl/swipt_link_ctrl.sv
// swipt_link_ctrl: frames TX bytes onto the duty-cycle modulator and grants RX windows.
// Define SWIPT_PARITY_EN to insert an even-parity bit between DATA and STOP.
module swipt_link_ctrl
    import swipt_pkg::*;
#(
    parameter logic [15:0] BIT_CYCLES   = 16'd500,
    parameter logic [15:0] GUARD_CYCLES = 16'd64,
    parameter logic [15:0] RX_CYCLES    = 16'd2000
) (
    input  logic              clk,
    input  logic              nrst,
    swipt_link_ctrl_if.slave  bus
);

    swipt_link_state_t state_q;
    logic [15:0] cnt_q;
    logic [3:0]  idx_q;
    logic [7:0]  byte_q;
    logic        write_q, read_q, data_q, busy_q, done_q, abort_q, live_q;
    logic        en, gnt_tx, gnt_rx, cnt_zero, rx_exit, upd;

    // live_q keeps tx_ready low while nrst is asserted even though IDLE is the reset state.
    assign en       = live_q && state_q == ST_IDLE && bus.swipt_alive_i;
    assign cnt_zero = cnt_q == 16'd0;
    assign rx_exit  = !bus.rx_req_i || cnt_zero;
    assign upd      = bus.swipt_alive_i && ((state_q == ST_STOP && cnt_zero) || (state_q == ST_RX && rx_exit));

    swipt_link_arb u_arb (
        .clk      (clk),
        .nrst     (nrst),
        .en_i     (en),
        .tx_req_i (bus.tx_valid_i),
        .rx_req_i (bus.rx_req_i),
        .upd_i    (upd),
        .upd_rx_i (state_q == ST_RX),
        .gnt_tx_o (gnt_tx),
        .gnt_rx_o (gnt_rx)
    );

    assign bus.tx_ready_o = en && !gnt_rx;
    assign bus.rx_grant_o = read_q;
    assign bus.program_o  = write_q ? SWIPT_PROG_TX : SWIPT_PROG_IDLE;
    assign bus.write_o    = write_q;
    assign bus.read_o     = read_q;
    assign bus.data_o     = data_q;
    assign bus.busy_o     = busy_q;
    assign bus.tx_done_o  = done_q;
    assign bus.abort_o    = abort_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            write_q <= 1'b0;
            read_q  <= 1'b0;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            live_q  <= 1'b1;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (state_q != ST_IDLE && !bus.swipt_alive_i) begin
                state_q <= ST_IDLE;
                byte_q  <= '0;
                write_q <= 1'b0;
                read_q  <= 1'b0;
                data_q  <= 1'b0;
                busy_q  <= 1'b0;
                abort_q <= 1'b1;
            end else begin
                cnt_q <= cnt_q - 16'd1;
                case (state_q)
                    ST_IDLE: begin
                        if (gnt_tx) begin
                            state_q <= ST_START;
                            byte_q  <= bus.tx_byte_i;
                            cnt_q   <= BIT_CYCLES - 16'd1;
                            write_q <= 1'b1;
                            data_q  <= SWIPT_START_BIT;
                            busy_q  <= 1'b1;
                        end else if (gnt_rx) begin
                            state_q <= ST_RX;
                            cnt_q   <= RX_CYCLES - 16'd1;
                            read_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_START: if (cnt_zero) begin
                        state_q <= ST_DATA;
                        cnt_q   <= BIT_CYCLES - 16'd1;
                        idx_q   <= '0;
                        data_q  <= byte_q[0];
                    end
                    ST_DATA: if (cnt_zero) begin
                        cnt_q <= BIT_CYCLES - 16'd1;
                        if (idx_q == 4'd7) begin
`ifdef SWIPT_PARITY_EN
                            state_q <= ST_PAR;
                            data_q  <= ^byte_q;
`else
                            state_q <= ST_STOP;
                            data_q  <= SWIPT_STOP_BIT;
`endif
                        end else begin
                            idx_q  <= idx_q + 4'd1;
                            data_q <= byte_q[idx_q[2:0] + 3'd1];
                        end
                    end
                    ST_PAR: if (cnt_zero) begin
                        state_q <= ST_STOP;
                        cnt_q   <= BIT_CYCLES - 16'd1;
                        data_q  <= SWIPT_STOP_BIT;
                    end
                    ST_STOP: if (cnt_zero) begin
                        state_q <= GUARD_CYCLES == 16'd0 ? ST_IDLE : ST_GUARD;
                        cnt_q   <= GUARD_CYCLES - 16'd1;
                        write_q <= 1'b0;
                        data_q  <= 1'b0;
                        busy_q  <= GUARD_CYCLES != 16'd0;
                        done_q  <= 1'b1;
                    end
                    ST_GUARD: if (cnt_zero) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    ST_RX: if (rx_exit) begin
                        state_q <= GUARD_CYCLES == 16'd0 ? ST_IDLE : ST_GUARD;
                        cnt_q   <= GUARD_CYCLES - 16'd1;
                        read_q  <= 1'b0;
                        busy_q  <= GUARD_CYCLES != 16'd0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
